// File: rtl/obi_credit_bridge.sv
// OBI decoupling bridge: per-channel request/response FIFOs, credit-limited
// outstanding transactions, and a quiesce/idle handshake for safe clock gating.

package obi_credit_bridge_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_a_chan_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;
endpackage

module obi_credit_bridge_fifo #(
    parameter int unsigned Depth  = 2,
    parameter type         data_t = logic
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  push_i,
    input  data_t data_i,
    input  logic  pop_i,
    output data_t head_o,
    output logic  full_o,
    output logic  empty_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    data_t           mem_q [Depth];
    data_t           mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        full_o   = (cnt_q == CntW'(Depth));
        empty_o  = (cnt_q == '0);
        head_o   = mem_q[rd_ptr_q];
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!push_i && pop_i) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module obi_credit_bridge_chan #(
    parameter int unsigned ReqDepth       = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         obi_req_t      = obi_credit_bridge_pkg::obi_req_t,
    parameter type         obi_rsp_t      = obi_credit_bridge_pkg::obi_rsp_t,
    parameter type         obi_a_chan_t   = obi_credit_bridge_pkg::obi_a_chan_t,
    parameter type         obi_r_chan_t   = obi_credit_bridge_pkg::obi_r_chan_t,
    parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  obi_req_t        sbr_req_i,
    output obi_rsp_t        sbr_rsp_o,
    input  logic            sbr_rready_i,
    output obi_req_t        mgr_req_o,
    input  obi_rsp_t        mgr_rsp_i,
    input  logic            quiesce_i,
    output logic [CntW-1:0] outstanding_o,
    output logic            idle_o
);
    logic            gnt;
    logic            req_push, req_pop, req_full, req_empty;
    logic            rsp_push, rsp_pop, rsp_full, rsp_empty;
    obi_a_chan_t     req_head;
    obi_r_chan_t     rsp_head;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] inflight_q, inflight_d;

    obi_credit_bridge_fifo #(.Depth(ReqDepth), .data_t(obi_a_chan_t)) u_req_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (req_push),
        .data_i (sbr_req_i.a),
        .pop_i  (req_pop),
        .head_o (req_head),
        .full_o (req_full),
        .empty_o(req_empty)
    );

    obi_credit_bridge_fifo #(.Depth(MaxOutstanding), .data_t(obi_r_chan_t)) u_rsp_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (rsp_push),
        .data_i (mgr_rsp_i.r),
        .pop_i  (rsp_pop),
        .head_o (rsp_head),
        .full_o (rsp_full),
        .empty_o(rsp_empty)
    );

    always_comb begin
        // Grant only from registered state, so a full FIFO never accepts.
        gnt      = !quiesce_i && !req_full && (outstanding_q < CntW'(MaxOutstanding));
        req_push = sbr_req_i.req && gnt;
        req_pop  = !req_empty && mgr_rsp_i.gnt;
        rsp_push = mgr_rsp_i.rvalid;
        rsp_pop  = !rsp_empty && sbr_rready_i;

        outstanding_d = outstanding_q;
        if (req_push && !rsp_pop) begin
            outstanding_d = outstanding_q + CntW'(1);
        end else if (!req_push && rsp_pop) begin
            outstanding_d = outstanding_q - CntW'(1);
        end

        inflight_d = inflight_q;
        if (req_pop && !rsp_push) begin
            inflight_d = inflight_q + CntW'(1);
        end else if (!req_pop && rsp_push) begin
            inflight_d = inflight_q - CntW'(1);
        end

        sbr_rsp_o        = '0;
        sbr_rsp_o.gnt    = gnt;
        sbr_rsp_o.rvalid = !rsp_empty;
        sbr_rsp_o.r      = rsp_head;
        mgr_req_o        = '0;
        mgr_req_o.req    = !req_empty;
        mgr_req_o.a      = req_head;
        outstanding_o    = outstanding_q;
        idle_o           = quiesce_i && (outstanding_q == '0) && req_empty;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            inflight_q    <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            inflight_q    <= inflight_d;
        end
    end

    // Credits guarantee room in the response FIFO; a violation means a protocol error.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(rsp_push && rsp_full));
            assert (!(mgr_rsp_i.rvalid && (inflight_q == '0)));
        end
    end
endmodule

module obi_credit_bridge #(
    parameter int unsigned NumChannels    = 2,
    parameter int unsigned ReqDepth       = 2,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         obi_req_t      = obi_credit_bridge_pkg::obi_req_t,
    parameter type         obi_rsp_t      = obi_credit_bridge_pkg::obi_rsp_t,
    parameter type         obi_a_chan_t   = obi_credit_bridge_pkg::obi_a_chan_t,
    parameter type         obi_r_chan_t   = obi_credit_bridge_pkg::obi_r_chan_t,
    parameter int unsigned CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  obi_req_t [NumChannels-1:0]        sbr_obi_req_i,
    output obi_rsp_t [NumChannels-1:0]        sbr_obi_rsp_o,
    input  logic     [NumChannels-1:0]        sbr_rready_i,
    output obi_req_t [NumChannels-1:0]        mgr_obi_req_o,
    input  obi_rsp_t [NumChannels-1:0]        mgr_obi_rsp_i,
    input  logic     [NumChannels-1:0]        quiesce_i,
    output logic     [NumChannels-1:0][CntW-1:0] outstanding_o,
    output logic     [NumChannels-1:0]        idle_o
);
    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        obi_credit_bridge_chan #(
            .ReqDepth      (ReqDepth),
            .MaxOutstanding(MaxOutstanding),
            .obi_req_t     (obi_req_t),
            .obi_rsp_t     (obi_rsp_t),
            .obi_a_chan_t  (obi_a_chan_t),
            .obi_r_chan_t  (obi_r_chan_t),
            .CntW          (CntW)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .sbr_req_i    (sbr_obi_req_i[c]),
            .sbr_rsp_o    (sbr_obi_rsp_o[c]),
            .sbr_rready_i (sbr_rready_i[c]),
            .mgr_req_o    (mgr_obi_req_o[c]),
            .mgr_rsp_i    (mgr_obi_rsp_i[c]),
            .quiesce_i    (quiesce_i[c]),
            .outstanding_o(outstanding_o[c]),
            .idle_o       (idle_o[c])
        );
    end
endmodule
